// File: rtl/sa_autosa_sdp_rdma_lat_fifo.sv
// Credit-managed read-latency buffer between the SDP RDMA address generator and the DMA interface.
// Requests are only forwarded while latency-FIFO credits remain, so returning beats always find room.
module sa_autosa_sdp_rdma_lat_fifo #(
  parameter int LAT_DEPTH = 64,
  parameter int REQ_PW    = 79,
  parameter int RSP_PW    = 257
) (
  input  logic              autosa_core_clk,
  input  logic              autosa_core_rstn,
  input  logic              reg2dp_src_ram_type,
  input  logic [REQ_PW-1:0] rdma_req_pd,
  input  logic              rdma_req_vld,
  output logic              rdma_req_rdy,
  output logic [REQ_PW-1:0] dma_rd_req_pd,
  output logic              dma_rd_req_vld,
  input  logic              dma_rd_req_rdy,
  output logic              dma_rd_req_ram_type,
  input  logic [RSP_PW-1:0] dma_rd_rsp_pd,
  input  logic              dma_rd_rsp_vld,
  output logic              dma_rd_rsp_rdy,
  output logic              dma_rd_rsp_ram_type,
  output logic              dma_rd_cdt_lat_fifo_pop,
  output logic [RSP_PW-1:0] rdma_rsp_pd,
  output logic              rdma_rsp_vld,
  input  logic              rdma_rsp_rdy,
  output logic              lat_fifo_idle
);

  localparam int AW = $clog2(LAT_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(LAT_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [CW-1:0]     credit_q, credit_d;
  logic              req_vld_q, req_vld_d;
  logic [REQ_PW-1:0] req_pd_q, req_pd_d;
  logic              ram_type_q, ram_type_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [RSP_PW-1:0] mem_q [LAT_DEPTH];

  logic          req_acc_s, dma_acc_s, push_s, pop_s;
  logic          full_s, empty_s, idle_s;
  logic [CW:0]   credit_eff_s;

  assign empty_s   = (occ_q == {CW{1'b0}});
  assign full_s    = (occ_q == CNT_FULL);
  assign pop_s     = !empty_s && rdma_rsp_rdy;
  assign push_s    = dma_rd_rsp_vld && !full_s;
  assign dma_acc_s = req_vld_q && dma_rd_req_rdy;
  assign idle_s    = (credit_q == CNT_FULL) && !req_vld_q;

  // Credits available for a new load: a beat consumed this cycle frees one immediately,
  // and a request still parked in the output register has already reserved one.
  assign credit_eff_s = {1'b0, credit_q} + {{CW{1'b0}}, pop_s} - {{CW{1'b0}}, req_vld_q};
  assign rdma_req_rdy = (credit_eff_s != {(CW+1){1'b0}}) && (!req_vld_q || dma_rd_req_rdy);
  assign req_acc_s    = rdma_req_vld && rdma_req_rdy;

  // Credit counter: one credit per request handed to DMA, returned per beat delivered.
  always_comb begin
    credit_d = credit_q;
    case ({dma_acc_s, pop_s})
      2'b10:   credit_d = credit_q - CNT_ONE;
      2'b01:   credit_d = credit_q + CNT_ONE;
      default: credit_d = credit_q;
    endcase
  end

  // One-entry request output register.
  always_comb begin
    req_vld_d = req_vld_q;
    req_pd_d  = req_pd_q;
    if (req_acc_s) begin
      req_vld_d = 1'b1;
      req_pd_d  = rdma_req_pd;
    end else if (dma_acc_s) begin
      req_vld_d = 1'b0;
    end else begin
      req_vld_d = req_vld_q;
    end
  end

  // RAM type only follows the register while nothing is in flight.
  always_comb begin
    ram_type_d = ram_type_q;
    if (idle_s) begin
      ram_type_d = reg2dp_src_ram_type;
    end else begin
      ram_type_d = ram_type_q;
    end
  end

  // Latency FIFO pointers and occupancy; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      credit_q   <= CNT_FULL;
      req_vld_q  <= 1'b0;
      req_pd_q   <= {REQ_PW{1'b0}};
      ram_type_q <= 1'b1;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      occ_q      <= {CW{1'b0}};
    end else begin
      credit_q   <= credit_d;
      req_vld_q  <= req_vld_d;
      req_pd_q   <= req_pd_d;
      ram_type_q <= ram_type_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Beat storage; contents are qualified by occupancy, so no reset is needed.
  always_ff @(posedge autosa_core_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= dma_rd_rsp_pd;
    end
  end

  assign dma_rd_req_pd           = req_pd_q;
  assign dma_rd_req_vld          = req_vld_q;
  assign dma_rd_req_ram_type     = ram_type_q;
  assign dma_rd_rsp_ram_type     = ram_type_q;
  assign dma_rd_rsp_rdy          = !full_s;
  assign rdma_rsp_vld            = !empty_s;
  assign rdma_rsp_pd             = mem_q[rd_ptr_q];
  assign dma_rd_cdt_lat_fifo_pop = pop_s;
  assign lat_fifo_idle           = idle_s;

  sa_autosa_sdp_rdma_lat_fifo_chk #(
    .LAT_DEPTH (LAT_DEPTH)
  ) u_chk (
    .clk          (autosa_core_clk),
    .rst_n        (autosa_core_rstn),
    .credit_cnt_i (credit_q),
    .occupancy_i  (occ_q),
    .req_accept_i (dma_acc_s),
    .rsp_accept_i (pop_s),
    .rsp_write_i  (dma_rd_rsp_vld),
    .fifo_full_i  (full_s)
  );

endmodule

// Invariants of the credit pool and latency FIFO.
module sa_autosa_sdp_rdma_lat_fifo_chk #(
  parameter int LAT_DEPTH = 64
) (
  input logic                         clk,
  input logic                         rst_n,
  input logic [$clog2(LAT_DEPTH):0]   credit_cnt_i,
  input logic [$clog2(LAT_DEPTH):0]   occupancy_i,
  input logic                         req_accept_i,
  input logic                         rsp_accept_i,
  input logic                         rsp_write_i,
  input logic                         fifo_full_i
);

  localparam int CW = $clog2(LAT_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(LAT_DEPTH);
  localparam logic [CW:0]   POOL     = (CW+1)'(LAT_DEPTH);

  logic [CW:0] pool_use_s;
  assign pool_use_s = {1'b0, credit_cnt_i} + {1'b0, occupancy_i};

  a_credit_max:   assert property (@(posedge clk) disable iff (!rst_n) credit_cnt_i <= CNT_FULL);
  a_credit_under: assert property (@(posedge clk) disable iff (!rst_n)
                    !((credit_cnt_i == {CW{1'b0}}) && req_accept_i && !rsp_accept_i));
  a_credit_over:  assert property (@(posedge clk) disable iff (!rst_n)
                    !((credit_cnt_i == CNT_FULL) && rsp_accept_i && !req_accept_i));
  a_occ_max:      assert property (@(posedge clk) disable iff (!rst_n) occupancy_i <= CNT_FULL);
  a_no_full_wr:   assert property (@(posedge clk) disable iff (!rst_n) !(rsp_write_i && fifo_full_i));
  a_pool:         assert property (@(posedge clk) disable iff (!rst_n) pool_use_s <= POOL);

endmodule
